// File: rtl/dmem_unit.sv
// Data-memory unit: byte/half/word/dword loads and stores on a block-RAM word array.
// Define DMEM_OUTREG_EN to register the formatted response (latency 2).
module dmem_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);

`ifdef DMEM_OUTREG_EN
  typedef enum logic [1:0] {IDLE, PIPE, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RESP} state_t;
`endif

  state_t state;

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] ramq;

  logic          accept;
  logic [OB-1:0] off;
  logic [AW-1:0] idx;
  logic [3:0]    amask;
  logic          mis;
  logic          size_bad;
  logic          range_bad;
  logic          fault;
  logic [7:0]    bmask;
  logic [NB-1:0] be;
  logic [XLEN-1:0] wsh;

  logic [OB-1:0] off_q;
  logic [1:0]    sz_q;
  logic          uns_q;
  logic          ld_q;
  logic          err_q;

  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] tmp;
  logic [XLEN-1:0] fmt;

  assign req_ready = (state == IDLE) && rst;
  assign accept    = req_valid && req_ready;
  assign off       = req_addr[OB-1:0];
  assign idx       = req_addr[OB +: AW];

  assign amask     = (4'd1 << req_size) - 4'd1;
  assign mis       = |(4'(off) & amask);
  assign size_bad  = (XLEN == 32) && (req_size == 2'd3);
  // Any set bit above the word array span is out of range; no wrap.
  assign range_bad = |(req_addr >> (OB + AW));
  assign fault     = mis | size_bad | range_bad;

  always_comb begin
    bmask = 8'h00;
    unique case (req_size)
      2'd0: bmask = 8'h01;
      2'd1: bmask = 8'h03;
      2'd2: bmask = 8'h0f;
      2'd3: bmask = 8'hff;
    endcase
  end

  assign be  = NB'(bmask) << off;
  assign wsh = req_wdata << {off, 3'b000};

  always_ff @(posedge clk) begin
    if (accept && !fault) begin
      if (req_we) begin
        for (int b = 0; b < NB; b++)
          if (be[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
      end else begin
        ramq <= mem[idx];
      end
    end
  end

  // Shift the field to the top, then back down logically or arithmetically.
  always_comb begin
    int bits;
    int sa;
    bits = 8 << sz_q;
    sa   = (bits >= XLEN) ? 0 : XLEN - bits;
    sh   = ramq >> {off_q, 3'b000};
    tmp  = sh << sa;
    fmt  = '0;
    if (ld_q && !err_q)
      fmt = uns_q ? (tmp >> sa) : XLEN'($signed(tmp) >>> sa);
  end

`ifdef DMEM_OUTREG_EN
  logic [XLEN-1:0] rdata_q;
  logic            erro_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      off_q   <= '0;
      sz_q    <= '0;
      uns_q   <= 1'b0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_OUTREG_EN
      rdata_q <= '0;
      erro_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            off_q <= off;
            sz_q  <= req_size;
            uns_q <= req_unsigned;
            ld_q  <= !req_we;
            err_q <= fault;
`ifdef DMEM_OUTREG_EN
            state <= PIPE;
`else
            state <= RESP;
`endif
          end
        end
`ifdef DMEM_OUTREG_EN
        PIPE: begin
          rdata_q <= fmt;
          erro_q  <= err_q;
          state   <= RESP;
        end
`endif
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);

`ifdef DMEM_OUTREG_EN
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid & erro_q;
`else
  assign rsp_rdata = rsp_valid ? fmt : '0;
  assign rsp_err   = rsp_valid & err_q;
`endif

endmodule

// File: tb/tb_dmem_unit.sv
// Directed vector bench for dmem_unit (XLEN=32, DEPTH=1024).
// Table of load/store records plus reset and backpressure sequences.
module tb_dmem_unit;

`ifdef DMEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int nchk;
  int nerr;

  dmem_unit #(.XLEN(32), .DEPTH(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input logic we, input logic [31:0] addr,
                              input logic [1:0] sz, input logic uns,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.sz = sz; v.uns = uns;
    v.wd = wd; v.rd = rd; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input vec_t v, input string nm);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_addr     = v.addr;
    req_size     = v.sz;
    req_unsigned = v.uns;
    req_wdata    = v.wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    issue(v, nm);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(LAT));
    chk({nm, " rdata"}, rsp_rdata, v.rd);
    chk({nm, " err"}, 32'(rsp_err), 32'(v.err));
    @(posedge clk); #1;
    chk({nm, " ready after hs"}, 32'(req_ready), 32'd1);
    chk({nm, " valid after hs"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rst = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_size = '0;
    req_unsigned = 1'b0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    tbl[0]  = mk(1, 32'h10,  2, 0, 32'hDEADBEEF, 32'h0,        0);
    tbl[1]  = mk(0, 32'h10,  2, 0, 32'h0,        32'hDEADBEEF, 0);
    tbl[2]  = mk(1, 32'h20,  2, 0, 32'h11223344, 32'h0,        0);
    tbl[3]  = mk(1, 32'h21,  0, 0, 32'h123456AA, 32'h0,        0);
    tbl[4]  = mk(0, 32'h20,  2, 0, 32'h0,        32'h1122AA44, 0);
    tbl[5]  = mk(0, 32'h21,  0, 0, 32'h0,        32'hFFFFFFAA, 0);
    tbl[6]  = mk(0, 32'h21,  0, 1, 32'h0,        32'h000000AA, 0);
    tbl[7]  = mk(0, 32'h23,  0, 0, 32'h0,        32'h00000011, 0);
    tbl[8]  = mk(0, 32'h22,  1, 1, 32'h0,        32'h00001122, 0);
    tbl[9]  = mk(1, 32'h30,  2, 0, 32'h0,        32'h0,        0);
    tbl[10] = mk(1, 32'h32,  1, 0, 32'hCAFE8001, 32'h0,        0);
    tbl[11] = mk(0, 32'h32,  1, 0, 32'h0,        32'hFFFF8001, 0);
    tbl[12] = mk(0, 32'h32,  1, 1, 32'h0,        32'h00008001, 0);
    tbl[13] = mk(0, 32'h30,  2, 0, 32'h0,        32'h80010000, 0);
    tbl[14] = mk(0, 32'h30,  1, 0, 32'h0,        32'h00000000, 0);
    tbl[15] = mk(1, 32'h0,   2, 0, 32'h0BADF00D, 32'h0,        0);
    tbl[16] = mk(0, 32'h13,  2, 0, 32'h0,        32'h0,        1);
    tbl[17] = mk(1, 32'h1000,2, 0, 32'h55,       32'h0,        1);
    tbl[18] = mk(0, 32'h0,   2, 0, 32'h0,        32'h0BADF00D, 0);
    tbl[19] = mk(0, 32'h31,  1, 0, 32'h0,        32'h0,        1);
    tbl[20] = mk(0, 32'h10,  3, 0, 32'h0,        32'h0,        1);
    tbl[21] = mk(1, 32'h21,  1, 0, 32'hFFFF,     32'h0,        1);
    tbl[22] = mk(0, 32'h20,  2, 0, 32'h0,        32'h1122AA44, 0);
    tbl[23] = mk(1, 32'hFFC, 2, 0, 32'hA5A55A5A, 32'h0,        0);
    tbl[24] = mk(0, 32'hFFC, 2, 0, 32'h0,        32'hA5A55A5A, 0);
    tbl[25] = mk(0, 32'h1004,2, 0, 32'h0,        32'h0,        1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 32'(rsp_valid), 32'd0);
    chk("rst err", 32'(rsp_err), 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++)
      run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while a load is in flight
    issue(mk(0, 32'h10, 2, 0, 32'h0, 32'h0, 0), "rload");
    rst = 1'b0;
    #1;
    chk("rload valid", 32'(rsp_valid), 32'd0);
    chk("rload err", 32'(rsp_err), 32'd0);
    chk("rload rdata", rsp_rdata, 32'd0);
    chk("rload ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rload valid2", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rload ready rel", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rload no rsp %0d", k), 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Reset right after a store was accepted: store must remain
    issue(mk(1, 32'h40, 2, 0, 32'h12345678, 32'h0, 0), "rstore");
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_vec(mk(0, 32'h40, 2, 0, 32'h0, 32'h12345678, 0), "rstore rd");

    // Backpressure on a load
    rsp_ready = 1'b0;
    issue(mk(0, 32'h10, 2, 0, 32'h0, 32'h0, 0), "bp");
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp valid %0d", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp rdata %0d", k), rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp ready %0d", k), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp ready after hs", 32'(req_ready), 32'd1);
    chk("bp valid after hs", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
